// File: rtl/c2c_mem_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// c2c_mem_arbiter: round-robin share of one c2c memory port among instr read,
// data read and data write masters, with a hung-transaction watchdog. Rev 1.0
// -----------------------------------------------------------------------------
module c2c_mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_re,
  input  logic [XLEN/8-1:0] instr_sel,
  input  logic [XLEN-1:0]   instr_addr,
  output logic              instr_ack,
  output logic [31:0]       instr_data,
  input  logic              dr_re,
  input  logic [XLEN/8-1:0] dr_sel,
  input  logic [XLEN-1:0]   dr_addr,
  output logic              dr_ack,
  output logic [XLEN-1:0]   dr_data,
  input  logic              dw_we,
  input  logic [XLEN/8-1:0] dw_sel,
  input  logic [XLEN-1:0]   dw_addr,
  input  logic [XLEN-1:0]   dw_data,
  output logic              dw_ack,
  output logic              mem_re,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_sel,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              bus_err
);

  localparam int            TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] ABORT_AT  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [1:0]    gnt, last, pick;
  logic [2:0]    req, rot;
  logic [TW-1:0] timer;
  logic          busy, abort, finish, start;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign req = {dw_we, dr_re, instr_re};

  // rot[0] is the requester right after 'last', rot[2] is 'last' itself
  always_comb begin
    rot = req;
    case (last)
      2'd0:    rot = {req[0], req[2], req[1]};
      2'd1:    rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase
  end

  assign pick   = rot[0] ? inc3(last) : (rot[1] ? inc3(inc3(last)) : last);
  assign busy   = (state == BUSY);
  assign abort  = (TIMEOUT > 0) && busy && !mem_ack && (timer == ABORT_AT);
  assign finish = busy && (mem_ack || abort);
  assign start  = !busy && (req != 3'b000);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = BUSY;
      BUSY:    if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt       <= 2'd0;
      last      <= 2'd2;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_sel   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      timer     <= '0;
    end else if (start) begin
      gnt    <= pick;
      last   <= pick;
      timer  <= '0;
      mem_re <= (pick != 2'd2);
      mem_we <= (pick == 2'd2);
      case (pick)
        2'd0: begin
          mem_sel   <= instr_sel;
          mem_addr  <= instr_addr;
          mem_wdata <= '0;
        end
        2'd1: begin
          mem_sel   <= dr_sel;
          mem_addr  <= dr_addr;
          mem_wdata <= '0;
        end
        default: begin
          mem_sel   <= dw_sel;
          mem_addr  <= dw_addr;
          mem_wdata <= dw_data;
        end
      endcase
    end else if (finish) begin
      mem_re <= 1'b0;
      mem_we <= 1'b0;
    end else if (busy && (timer != TIMER_MAX)) begin
      timer <= timer + TW'(1);
    end
  end

  // Responses route straight through to the granted master; an abort zeroes data
  assign instr_ack  = finish && (gnt == 2'd0);
  assign dr_ack     = finish && (gnt == 2'd1);
  assign dw_ack     = finish && (gnt == 2'd2);
  assign instr_data = (busy && !abort && gnt == 2'd0) ? mem_rdata[31:0] : 32'd0;
  assign dr_data    = (busy && !abort && gnt == 2'd1) ? mem_rdata : '0;
  assign bus_err    = abort;

endmodule
`default_nettype wire

// File: tb/tb_c2c_mem_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_c2c_mem_arbiter: directed stimulus with a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_c2c_mem_arbiter;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            instr_re = 1'b0, dr_re = 1'b0, dw_we = 1'b0;
  logic [3:0]      instr_sel = '0, dr_sel = '0, dw_sel = '0;
  logic [31:0]     instr_addr = '0, dr_addr = '0, dw_addr = '0, dw_data = '0;
  logic            instr_ack, dr_ack, dw_ack;
  logic [31:0]     instr_data, dr_data;
  logic            mem_re, mem_we, bus_err;
  logic [3:0]      mem_sel;
  logic [31:0]     mem_addr, mem_wdata;
  logic            mem_ack = 1'b0;
  logic [31:0]     mem_rdata = '0;

  int checks = 0;
  int failures = 0;
  bit running = 1'b0;
  int grant_log[$];

  c2c_mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_re(instr_re), .instr_sel(instr_sel), .instr_addr(instr_addr),
    .instr_ack(instr_ack), .instr_data(instr_data),
    .dr_re(dr_re), .dr_sel(dr_sel), .dr_addr(dr_addr),
    .dr_ack(dr_ack), .dr_data(dr_data),
    .dw_we(dw_we), .dw_sel(dw_sel), .dw_addr(dw_addr), .dw_data(dw_data),
    .dw_ack(dw_ack),
    .mem_re(mem_re), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: one outstanding transaction, identified by master and its
  // 1-based busy-cycle number; strobes clear on completion, other fields persist.
  bit          m_busy = 1'b0;
  int          m_who = 0, m_last = 2, m_cyc = 0;
  logic        m_re = 1'b0, m_we = 1'b0;
  logic [3:0]  m_sel = '0;
  logic [31:0] m_addr = '0, m_wdata = '0;

  function automatic bit wants(input int c);
    return (c == 0) ? instr_re : (c == 1) ? dr_re : dw_we;
  endfunction

  function automatic bit m_abort();
    return (TIMEOUT > 0) && m_busy && !mem_ack && (m_cyc == TIMEOUT);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_busy = 1'b0; m_who = 0; m_last = 2; m_cyc = 0;
        m_re = 1'b0; m_we = 1'b0; m_sel = '0; m_addr = '0; m_wdata = '0;
      end else if (m_busy) begin
        if (mem_ack || m_abort()) begin
          m_busy = 1'b0; m_re = 1'b0; m_we = 1'b0;
        end else begin
          m_cyc++;
        end
      end else begin
        bit got;
        got = 1'b0;
        for (int k = 1; k <= 3; k++) begin
          int c;
          c = (m_last + k) % 3;
          if (!got && wants(c)) begin
            got = 1'b1; m_busy = 1'b1; m_who = c; m_last = c; m_cyc = 1;
            m_re = (c != 2); m_we = (c == 2);
            m_sel   = (c == 0) ? instr_sel  : (c == 1) ? dr_sel  : dw_sel;
            m_addr  = (c == 0) ? instr_addr : (c == 1) ? dr_addr : dw_addr;
            m_wdata = (c == 2) ? dw_data : 32'd0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (running) begin
        bit ab, fin;
        ab  = m_abort();
        fin = m_busy && (mem_ack || ab);
        chk("instr_ack",  instr_ack, fin && m_who == 0);
        chk("dr_ack",     dr_ack,    fin && m_who == 1);
        chk("dw_ack",     dw_ack,    fin && m_who == 2);
        chk("instr_data", instr_data, (m_busy && m_who == 0 && !ab) ? mem_rdata : 32'd0);
        chk("dr_data",    dr_data,    (m_busy && m_who == 1 && !ab) ? mem_rdata : 32'd0);
        chk("bus_err",    bus_err,   ab);
        chk("mem_re",     mem_re,    m_re);
        chk("mem_we",     mem_we,    m_we);
        chk("mem_sel",    mem_sel,   m_sel);
        chk("mem_addr",   mem_addr,  m_addr);
        chk("mem_wdata",  mem_wdata, m_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the strobe, acks after dly more cycles, drops the acked master's request
  task automatic serve(input int lat, input int dly, input logic [31:0] rd, input string nm,
                       output logic [2:0] a, output logic [31:0] d);
    int n;
    n = 0;
    while (!(mem_re || mem_we) && n < 20) begin
      step();
      n++;
    end
    chk({nm, " strobe latency"}, n, lat);
    repeat (dly) step();
    mem_ack = 1'b1; mem_rdata = rd;
    #1;
    a = {dw_ack, dr_ack, instr_ack};
    d = instr_data | dr_data;
    for (int i = 0; i < 3; i++) if (a[i]) grant_log.push_back(i);
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    if (a[0]) instr_re = 1'b0;
    if (a[1]) dr_re = 1'b0;
    if (a[2]) dw_we = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  a;
    logic [31:0] d;
    reset_n = 1'b0;
    #1;
    chk("reset mem_re", mem_re, 1'b0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset bus_err", bus_err, 1'b0);
    running = 1'b1;
    step(); step();
    reset_n = 1'b1;
    step();

    // single instr read, ack 3 cycles after strobe
    instr_re = 1'b1; instr_addr = 32'h100; instr_sel = 4'hF;
    serve(1, 3, 32'hDEADBEEF, "t1", a, d);
    chk("t1 ack vector", a, 3'b001);
    chk("t1 instr_data", d, 32'hDEADBEEF);
    chk("t1 mem_re after", mem_re, 1'b0);

    // all three at once after reset
    pulse_reset();
    grant_log.delete();
    instr_re = 1'b1; instr_addr = 32'h200;
    dr_re = 1'b1; dr_addr = 32'h300; dr_sel = 4'hC;
    dw_we = 1'b1; dw_addr = 32'h400; dw_sel = 4'h1; dw_data = 32'h55AA;
    serve(1, 1, 32'h11111111, "t2a", a, d);
    instr_re = 1'b1;
    serve(1, 1, 32'h22222222, "t2b", a, d);
    serve(1, 1, 32'h33333333, "t2c", a, d);
    serve(1, 1, 32'h44444444, "t2d", a, d);
    chk("t2 grant count", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      chk("t2 grant0", grant_log[0], 0);
      chk("t2 grant1", grant_log[1], 1);
      chk("t2 grant2", grant_log[2], 2);
      chk("t2 grant3", grant_log[3], 0);
    end

    // data write
    dw_we = 1'b1; dw_addr = 32'h20; dw_sel = 4'b0011; dw_data = 32'h1234;
    step();
    chk("t3 mem_we", mem_we, 1'b1);
    chk("t3 mem_re", mem_re, 1'b0);
    chk("t3 mem_sel", mem_sel, 4'b0011);
    chk("t3 mem_addr", mem_addr, 32'h20);
    chk("t3 mem_wdata", mem_wdata, 32'h1234);
    serve(0, 2, 32'h0, "t3", a, d);
    chk("t3 ack vector", a, 3'b100);

    // watchdog abort, then ack on the abort cycle
    dr_re = 1'b1; dr_addr = 32'h500; dr_sel = 4'hF; mem_rdata = 32'hCAFEF00D;
    step();
    repeat (6) step();
    chk("t4 bus_err cyc7", bus_err, 1'b0);
    chk("t4 dr_ack cyc7", dr_ack, 1'b0);
    step();
    chk("t4 bus_err cyc8", bus_err, 1'b1);
    chk("t4 dr_ack cyc8", dr_ack, 1'b1);
    chk("t4 dr_data cyc8", dr_data, 32'd0);
    dr_re = 1'b0;
    step();
    chk("t4 idle mem_re", mem_re, 1'b0);
    chk("t4 idle bus_err", bus_err, 1'b0);
    dr_re = 1'b1;
    step();
    repeat (7) step();
    mem_ack = 1'b1;
    #1;
    chk("t4 ack-wins bus_err", bus_err, 1'b0);
    chk("t4 ack-wins dr_ack", dr_ack, 1'b1);
    chk("t4 ack-wins dr_data", dr_data, 32'hCAFEF00D);
    dr_re = 1'b0;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("t4 end mem_re", mem_re, 1'b0);

    // async reset mid transaction
    dr_re = 1'b1; dr_addr = 32'h44; dr_sel = 4'h6;
    step(); step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5 mem_re", mem_re, 1'b0);
    chk("t5 mem_addr", mem_addr, 32'd0);
    chk("t5 mem_sel", mem_sel, 4'd0);
    chk("t5 bus_err", bus_err, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h99;
    #2;
    chk("t5 dr_ack in reset", dr_ack, 1'b0);
    chk("t5 dr_data in reset", dr_data, 32'd0);
    dr_re = 1'b0;
    step(); step();
    reset_n = 1'b1;
    #1;
    chk("t5 late ack dr_ack", dr_ack, 1'b0);
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("t5 late ack mem_re", mem_re, 1'b0);

    // stray ack while idle
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    #1;
    chk("t6 instr_ack", instr_ack, 1'b0);
    chk("t6 dr_ack", dr_ack, 1'b0);
    chk("t6 dw_ack", dw_ack, 1'b0);
    chk("t6 instr_data", instr_data, 32'd0);
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("t6 mem_re", mem_re, 1'b0);
    chk("t6 mem_we", mem_we, 1'b0);
    instr_re = 1'b1; instr_addr = 32'h600;
    serve(1, 0, 32'h0BADF00D, "t6", a, d);
    chk("t6 follow-up ack", a, 3'b001);
    chk("t6 follow-up data", d, 32'h0BADF00D);

    step();
    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
